mp4_sram_1rw: RTL and testbench

MP4_SRAM_1RW -- requirements
Module: mp4_sram_1rw

---
 rtl/mp4_sram_1rw.sv | 111 +++++++++++
 tb/tb_mp4_sram_1rw.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mp4_sram_1rw.sv
// mp4_sram_1rw: single-port synchronous SRAM with per-section write mask,
// registered read data and an optional zero-fill sweep after reset.
module mp4_sram_1rw #(
    parameter int DATA_WIDTH     = 23,
    parameter int ADDR_WIDTH     = 4,
    parameter int WMASK_WIDTH    = 1,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   ready0
);

    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int SW        = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic                    acc_en;

    // Replace only the sections whose mask bit is set; the rest keep old data.
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0]  old_word,
        input logic [DATA_WIDTH-1:0]  new_word,
        input logic [WMASK_WIDTH-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (mask[i]) begin
                res[i*SW +: SW] = new_word[i*SW +: SW];
            end
        end
        return res;
    endfunction

    assign rd_word = mem[addr0];
    assign wr_word = merge_word(rd_word, din0, wmask0);
    // Accesses are only honoured when idle and not being reset.
    assign acc_en  = (state == ST_IDLE) && !csb0 && !rst0;

    // Control FSM: reset either starts the zero-fill sweep or goes straight to idle.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            clr_ptr <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state  <= ST_CLEAR;
                ready0 <= 1'b0;
            end else begin
                state  <= ST_IDLE;
                ready0 <= 1'b1;
            end
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state  <= ST_IDLE;
                        ready0 <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ready0 <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: clear sweep has priority, otherwise masked writes when idle.
    always_ff @(posedge clk0) begin
        if (!rst0) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (acc_en && !web0) begin
                mem[addr0] <= wr_word;
            end
        end
    end

    // Read data register: loads on reads, and on writes only in write-first mode.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            dout0 <= '0;
        end else if (acc_en) begin
            if (web0) begin
                dout0 <= rd_word;
            end else if (WRITE_FIRST != 0) begin
                dout0 <= wr_word;
            end
        end
    end

endmodule

// File: tb/tb_mp4_sram_1rw.sv
// tb_mp4_sram_1rw: directed bench for mp4_sram_1rw covering three builds:
// defaults, 32-bit/4-section write-first, and no clear-on-reset.
module tb_mp4_sram_1rw;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    int total = 0;
    int bad   = 0;

    // Build A: all defaults
    logic        a_rst, a_csb, a_web;
    logic [0:0]  a_wmask;
    logic [3:0]  a_addr;
    logic [22:0] a_din, a_dout;
    logic        a_rdy;

    // Build B: 32-bit word, four byte sections, write-first
    logic        b_rst, b_csb, b_web;
    logic [3:0]  b_wmask;
    logic [3:0]  b_addr;
    logic [31:0] b_din, b_dout;
    logic        b_rdy;

    // Build C: no clear on reset
    logic        c_rst, c_csb, c_web;
    logic [0:0]  c_wmask;
    logic [3:0]  c_addr;
    logic [22:0] c_din, c_dout;
    logic        c_rdy;

    mp4_sram_1rw u_dut_a (
        .clk0(clk0), .rst0(a_rst), .csb0(a_csb), .web0(a_web), .wmask0(a_wmask),
        .addr0(a_addr), .din0(a_din), .dout0(a_dout), .ready0(a_rdy)
    );

    mp4_sram_1rw #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_WIDTH(4), .WRITE_FIRST(1),
                   .CLEAR_ON_RESET(1)) u_dut_b (
        .clk0(clk0), .rst0(b_rst), .csb0(b_csb), .web0(b_web), .wmask0(b_wmask),
        .addr0(b_addr), .din0(b_din), .dout0(b_dout), .ready0(b_rdy)
    );

    mp4_sram_1rw #(.CLEAR_ON_RESET(0)) u_dut_c (
        .clk0(clk0), .rst0(c_rst), .csb0(c_csb), .web0(c_web), .wmask0(c_wmask),
        .addr0(c_addr), .din0(c_din), .dout0(c_dout), .ready0(c_rdy)
    );

    task automatic cycle();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_csb = 1'b1; a_web = 1'b1; a_wmask = 1'b1; a_addr = '0; a_din = '0;
        b_rst = 1'b1; b_csb = 1'b1; b_web = 1'b1; b_wmask = 4'hF; b_addr = '0; b_din = '0;
        c_rst = 1'b1; c_csb = 1'b1; c_web = 1'b1; c_wmask = 1'b1; c_addr = '0; c_din = '0;

        // Reset edge (posedge 1)
        cycle();
        chk("a_rst_ready", 32'(a_rdy), 32'd0);
        chk("a_rst_dout", 32'(a_dout), 32'd0);
        chk("c_rst_ready", 32'(c_rdy), 32'd1);
        chk("c_rst_dout", 32'(c_dout), 32'd0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // Clear sweep: ready low after posedges 2..16, high after posedge 17
        for (int i = 2; i <= 16; i++) begin
            cycle();
            chk($sformatf("a_clear_ready_%0d", i), 32'(a_rdy), 32'd0);
        end
        cycle();
        chk("a_ready_rise", 32'(a_rdy), 32'd1);
        chk("b_ready_rise", 32'(b_rdy), 32'd1);

        // Every address reads zero after the sweep
        a_csb = 1'b0; a_web = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_addr = 4'(i);
            cycle();
            chk($sformatf("a_zero_rd_%0d", i), 32'(a_dout), 32'd0);
        end

        // Write addr 5 then read it back; write leaves dout0 alone
        a_web = 1'b0; a_addr = 4'd5; a_din = 23'h7ABCDE;
        cycle();
        chk("a_wr5_dout_hold", 32'(a_dout), 32'd0);
        a_web = 1'b1;
        cycle();
        chk("a_rd5", 32'(a_dout), 32'h7ABCDE);

        // Read addr 2 (zero) then write 1: dout0 holds in read-first mode
        a_addr = 4'd2;
        cycle();
        chk("a_rd2", 32'(a_dout), 32'd0);
        a_web = 1'b0; a_din = 23'h1;
        cycle();
        chk("a_wr2_dout_hold", 32'(a_dout), 32'd0);
        a_web = 1'b1;
        cycle();
        chk("a_rd2_after_wr", 32'(a_dout), 32'd1);

        // Deselected write does nothing
        a_csb = 1'b1; a_web = 1'b0; a_addr = 4'd5; a_din = 23'h123456;
        cycle();
        chk("a_csb_dout_hold", 32'(a_dout), 32'd1);
        // All-zero mask writes nothing
        a_csb = 1'b0; a_web = 1'b0; a_wmask = 1'b0; a_addr = 4'd5; a_din = 23'h000F0F;
        cycle();
        a_web = 1'b1; a_wmask = 1'b1;
        cycle();
        chk("a_rd5_unchanged", 32'(a_dout), 32'h7ABCDE);

        // dout0 holds while idle
        a_csb = 1'b1; a_web = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("a_idle_hold", 32'(a_dout), 32'h7ABCDE);

        // Write-first build: full write, partial write, then read
        b_csb = 1'b0; b_web = 1'b0; b_addr = 4'd7; b_wmask = 4'hF; b_din = 32'h11223344;
        cycle();
        chk("b_wr_full_dout", b_dout, 32'h11223344);
        b_wmask = 4'b0101; b_din = 32'hAABBCCDD;
        cycle();
        chk("b_wr_part_dout", b_dout, 32'h11BB33DD);
        b_web = 1'b1; b_wmask = 4'hF;
        cycle();
        chk("b_rd7", b_dout, 32'h11BB33DD);
        b_addr = 4'd2;
        cycle();
        chk("b_rd2", b_dout, 32'd0);
        b_web = 1'b0; b_din = 32'h1;
        cycle();
        chk("b_wr2_dout", b_dout, 32'h1);
        b_csb = 1'b1; b_web = 1'b1;
        cycle();
        chk("b_idle_hold", b_dout, 32'h1);

        // Reset restart mid-sweep, with writes to addr 3 attempted throughout
        a_rst = 1'b1;
        cycle();
        a_rst = 1'b0;
        a_csb = 1'b0; a_web = 1'b0; a_addr = 4'd3; a_din = 23'h7FFFFF;
        for (int i = 0; i < 9; i++) cycle();
        chk("a_mid_clear_ready", 32'(a_rdy), 32'd0);
        a_rst = 1'b1;
        cycle();
        chk("a_restart_ready", 32'(a_rdy), 32'd0);
        a_rst = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            chk($sformatf("a_restart_ready_%0d", i), 32'(a_rdy), 32'd0);
        end
        a_csb = 1'b1; a_web = 1'b1;
        cycle();
        chk("a_restart_rise", 32'(a_rdy), 32'd1);
        chk("a_restart_dout", 32'(a_dout), 32'd0);
        a_csb = 1'b0; a_addr = 4'd3;
        cycle();
        chk("a_rd3_after_clear", 32'(a_dout), 32'd0);
        a_addr = 4'd5;
        cycle();
        chk("a_rd5_after_clear", 32'(a_dout), 32'd0);
        a_csb = 1'b1;

        // No-clear build: memory survives reset, and reset blocks a same-cycle write
        c_csb = 1'b0; c_web = 1'b0; c_addr = 4'd4; c_din = 23'h0055AA;
        cycle();
        c_rst = 1'b1; c_din = 23'h001111;
        cycle();
        chk("c_rst_ready_idle", 32'(c_rdy), 32'd1);
        chk("c_rst_dout_zero", 32'(c_dout), 32'd0);
        c_rst = 1'b0; c_web = 1'b1;
        cycle();
        chk("c_rd4_kept", 32'(c_dout), 32'h0055AA);
        c_csb = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
